// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the ping-pong feed in front of the 2:1 byte mux
package mux_pkg;
  localparam int MUX_WIDTH = 8;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Occupancy is full_a + full_b
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;
endpackage

// File: rtl/mux_pp_bank.sv
// rtl/mux_pp_bank.sv - one ping-pong bank: a data register plus its full flag
module mux_pp_bank #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);
  logic [WIDTH-1:0] q_q;
  logic             full_q;

  // A write only targets an empty bank and a read only a full one, so the two never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      full_q <= 1'b0;
    end else if (wr_en) begin
      q_q    <= d;
      full_q <= 1'b1;
    end else if (rd_en) begin
      full_q <= 1'b0;
    end
  end

  assign q    = q_q;
  assign full = full_q;
endmodule

// File: rtl/mux_pingpong_feed.sv
// rtl/mux_pingpong_feed.sv - two-bank ping-pong feeding the 2:1 byte mux a/b/s
// Optional transfer counter xfer_cnt is built when MUX_PP_STATS_EN is defined.
module mux_pingpong_feed
  import mux_pkg::*;
#(
  parameter int WIDTH = MUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             s,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MUX_PP_STATS_EN
  ,
  output logic [15:0]      xfer_cnt
`endif
);
  logic wr_ptr_q, wr_ptr_d;
  logic rd_ptr_q, rd_ptr_d;
  logic full_a, full_b;
  logic wr_fire, rd_fire;

  assign in_ready  = !rst && !((wr_ptr_q == BANK_B) ? full_b : full_a);
  assign out_valid = (rd_ptr_q == BANK_B) ? full_b : full_a;
  assign s         = rd_ptr_q;
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ wr_fire;
    rd_ptr_d = rd_ptr_q ^ rd_fire;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= BANK_A;
      rd_ptr_q <= BANK_A;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  mux_pp_bank #(.WIDTH(WIDTH)) u_bank_a (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_fire && (wr_ptr_q == BANK_A)),
    .rd_en (rd_fire && (rd_ptr_q == BANK_A)),
    .d     (in_data),
    .q     (a),
    .full  (full_a)
  );

  mux_pp_bank #(.WIDTH(WIDTH)) u_bank_b (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_fire && (wr_ptr_q == BANK_B)),
    .rd_en (rd_fire && (rd_ptr_q == BANK_B)),
    .d     (in_data),
    .q     (b),
    .full  (full_b)
  );

`ifdef MUX_PP_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q + {15'd0, rd_fire};
  end

  always_ff @(posedge clk) begin
    if (rst) xfer_cnt_q <= '0;
    else     xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif
endmodule

// File: tb/tb_mux_pingpong_feed.sv
// tb/tb_mux_pingpong_feed.sv - scoreboard bench for mux_pingpong_feed
module tb_mux_pingpong_feed;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] a, b;
  logic       s;
  logic       out_valid;
  logic       out_ready;
`ifdef MUX_PP_STATS_EN
  logic [15:0] xfer_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  mux_pingpong_feed dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a         (a),
    .b         (b),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_PP_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Producer side: every accepted byte becomes an expected output.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) sb.push_back(in_data);
  end

  // Consumer side: every read handshake must present the oldest expected byte on x.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) check_eq("sb_underflow", {24'd0, (s ? b : a)}, 32'hFFFF_FFFF);
      else                check_eq("x_order", {24'd0, (s ? b : a)}, {24'd0, sb.pop_front()});
    end
  end

  initial begin
    // 1. reset with a pending input
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
    step();
    check_eq("rst_a", a, 0);
    check_eq("rst_b", b, 0);
    check_eq("rst_s", s, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    step();
    check_eq("rst2_in_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
`ifdef MUX_PP_STATS_EN
    check_eq("rst_xfer_cnt", xfer_cnt, 0);
`endif

    // 2. ordered fill, third byte refused
    in_valid = 1'b1; in_data = 8'h11;
    step();
    check_eq("lat1_out_valid", out_valid, 1);
    in_data = 8'h22;
    step();
    check_eq("fill_a", a, 8'h11);
    check_eq("fill_b", b, 8'h22);
    check_eq("fill_in_ready", in_ready, 0);
    check_eq("fill_out_valid", out_valid, 1);
    check_eq("fill_s", s, 0);
    in_data = 8'h33;
    step();
    check_eq("full_a_hold", a, 8'h11);
    check_eq("full_b_hold", b, 8'h22);
    check_eq("full_sb_depth", sb.size(), 2);
    in_valid = 1'b0;

    // 3. drain
    out_ready = 1'b1;
    #1;
    check_eq("drain0_x", (s ? b : a), 8'h11);
    step();
    check_eq("drain1_s", s, 1);
    check_eq("drain1_x", (s ? b : a), 8'h22);
    step();
    check_eq("drain_out_valid", out_valid, 0);
    check_eq("drain_s", s, 0);
    step();
    check_eq("empty_s_hold", s, 0);
    out_ready = 1'b0;

    // 4. streaming at one byte per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_data = 8'(i);
      #1;
      check_eq("stream_in_ready", in_ready, 1);
      step();
      check_eq("stream_out_valid", out_valid, 1);
      check_eq("stream_x", (s ? b : a), i);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_end_out_valid", out_valid, 0);
    check_eq("stream_sb_empty", sb.size(), 0);

    // 5. stall with occupancy 1
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h77;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_a", a, 8'h77);
      check_eq("stall_b", b, 8'h08);
      check_eq("stall_s", s, 0);
      check_eq("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b1; in_data = 8'h88;
    #1;
    check_eq("stall_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("stall_next_b", b, 8'h88);
    check_eq("stall_next_a", a, 8'h77);
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    check_eq("stall_drained", sb.size(), 0);
`ifdef MUX_PP_STATS_EN
    check_eq("cnt_before_rst", xfer_cnt, 12);
`endif

    // 6. reset at occupancy 2
    in_valid = 1'b1; in_data = 8'h99;
    step();
    in_data = 8'hAB;
    step();
    in_valid = 1'b0;
    check_eq("occ2_in_ready", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_a", a, 0);
`ifdef MUX_PP_STATS_EN
    check_eq("mid_rst_cnt", xfer_cnt, 0);
`endif
    in_valid = 1'b1; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    check_eq("after_rst_a", a, 8'h5A);
    check_eq("after_rst_s", s, 0);
    check_eq("after_rst_out_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("after_rst_empty", out_valid, 0);
`ifdef MUX_PP_STATS_EN
    check_eq("after_rst_cnt", xfer_cnt, 1);
`endif
    check_eq("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
